window_3x3_linebuf: RTL
=======================

// Module: window_3x3_linebuf
// PURPOSE
//  Upstream feeder of the 3x3 mean stage. Takes a raster-order grey pixel stream (row-major, one pixel per accepted cycle),
//  stores the two previous rows in line buffers, and emits each fully-interior 3x3 window as nine parallel pixels.
//  Output order matches the mean stage's data_i_0..data_i_8 inputs. data_o_0 is top-left and data_o_8 is bottom-right.
// PARAMETERS
//  WIDTH   320  pixels per row (>=3)
//  HEIGHT  240  rows per frame (>=3)
//  DATA_W  8    bits per pixel
// PORTS
//  clk_i_win     in   1       single clock, all logic rising-edge
//  rst_i_win     in   1       synchronous, active-high reset
//  en_i_win      in   1       input pixel valid
//  rdy_i_win     in   1       downstream may take a new window; throttles input
//  rdy_o_win     out  1       = rdy_i_win (combinational passthrough to pixel source)
//  sof_i_win     in   1       qualifies the current accepted pixel as pixel (0,0) of a new frame
//  data_i        in   DATA_W  input pixel
//  data_o_0..8   out  DATA_W  window pixels: row-major, top row first
//  valid_o_win   out  1       1-cycle pulse: data_o_* hold a new window
//  frame_done_o  out  1       1-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//  Acceptance and counters
//   - accept = en_i_win & rdy_i_win. Nothing changes on cycles without accept, except that the pulses drop.
//   - col counter counts 0..WIDTH-1 on each accept. row counter counts 0..HEIGHT-1 on col wrap.
//   - Both counters wrap to 0 after (HEIGHT-1, WIDTH-1).
//  Line buffers
//   - Two WIDTH-deep RAMs, lb1 (row r-1) and lb2 (row r-2), both addressed by col.
//   - On accept: read lb1[c] and lb2[c]; write lb2[c] <= lb1[c] and lb1[c] <= data_i.
//   - The 3x3 register window shifts one column left. The new right column is {lb2[c], lb1[c], data_i}.
//  Window output
//   - valid_o_win asserts the cycle after an accept with r>=2 and c>=2. Latency is 1 clock.
//   - The window then covers rows r-2..r and cols c-2..c. Its origin is (r-2, c-2).
//   - Windows with c<2 are suppressed, so stale columns from the previous row are never exposed.
//   - Windows per frame = (HEIGHT-2)*(WIDTH-2). Default is 75684.
//   - data_o_* hold their value until the next accept. They are combinational-free register outputs.
//  FSM (state_q)
//   - S_IDLE: waiting for pixel (0,0). The first accept moves to S_FILL.
//   - S_FILL: rows 0..1, no windows. Moves to S_RUN on the accept that wraps row 1 to row 2.
//   - S_RUN: rows 2..HEIGHT-1, windows emitted. The accept of (HEIGHT-1, WIDTH-1) returns to S_IDLE.
//     frame_done_o pulses the next cycle, coincident with the last valid_o_win.
//  Boundary conditions
//   - sof_i_win with accept: that pixel is taken as (0,0), counters are forced, state becomes S_FILL, no window.
//   - sof_i_win mid-frame: the partial frame is abandoned, no frame_done_o, and line buffer contents are not cleared.
//   - sof_i_win without accept is ignored.
//   - rdy_i_win low: input is stalled, window registers hold, and valid_o_win stays 0.
//   - Reset, including mid-frame: counters 0, state S_IDLE, data_o_* 0, valid_o_win 0, frame_done_o 0.
//     RAM contents are not reset, and are unobservable until rows are refilled.
//   - No arithmetic beyond the counters. Counter width is $clog2(WIDTH) and $clog2(HEIGHT) bits, with explicit compare-and-wrap.
// CONFIGURATION
//  WIN_COORD_EN
//   - Defined: adds output ports win_row_o [$clog2(HEIGHT)] and win_col_o [$clog2(WIDTH)].
//     They carry the window origin (r-2, c-2), registered together with data_o_* and valid on valid_o_win. Reset value is 0.
//   - Undefined: the ports and their registers are absent. All other behaviour is identical.
// TESTING  (WIDTH=5, HEIGHT=4, pixel value = raster index 0..19, en=rdy=1 unless stated)
//  1. Stream the full frame with sof on pixel 0.
//     -> First valid_o_win one cycle after pixel 12: data_o_0..8 = 0,1,2,5,6,7,10,11,12.
//     -> Exactly 6 windows; the last is 7,8,9,12,13,14,17,18,19.
//     -> frame_done_o pulses once, with the last window.
//  2. Same frame with rdy_i_win low for 3 cycles at pixel 11.
//     -> rdy_o_win follows rdy_i_win and no pixel is accepted during the stall.
//     -> Windows are identical to test 1, with no duplicated valid pulse.
//  3. Toggle en_i_win randomly (50%).
//     -> Window contents and count match test 1.
//     -> valid_o_win appears only 1 cycle after a qualifying accept.
//  4. Assert sof_i_win at pixel 8 of frame 1, then stream 20 pixels.
//     -> No frame_done_o for frame 1.
//     -> The new frame yields 6 windows, the first = 0,1,2,5,6,7,10,11,12.
//  5. Assert rst_i_win for 1 cycle at pixel 13.
//     -> Next cycle all outputs are 0 and state is S_IDLE.
//     -> A fresh sof frame behaves exactly as test 1.
//  6. Two back-to-back frames without a gap.
//     -> 12 windows and 2 frame_done_o pulses.
//     -> With WIN_COORD_EN, the window origins are (0,0)..(1,2) for each frame.

Source files
------------

// File: rtl/window_3x3_linebuf.sv
// Raster pixel stream to 3x3 fully-interior windows, built from two line buffers.
// Optional macro WIN_COORD_EN adds the registered window-origin outputs win_row_o/win_col_o.
module window_3x3_linebuf #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned DATA_W = 8
) (
    input  logic                      clk_i_win,
    input  logic                      rst_i_win,
    input  logic                      en_i_win,
    input  logic                      rdy_i_win,
    output logic                      rdy_o_win,
    input  logic                      sof_i_win,
    input  logic [DATA_W-1:0]         data_i,
    output logic [DATA_W-1:0]         data_o_0,
    output logic [DATA_W-1:0]         data_o_1,
    output logic [DATA_W-1:0]         data_o_2,
    output logic [DATA_W-1:0]         data_o_3,
    output logic [DATA_W-1:0]         data_o_4,
    output logic [DATA_W-1:0]         data_o_5,
    output logic [DATA_W-1:0]         data_o_6,
    output logic [DATA_W-1:0]         data_o_7,
    output logic [DATA_W-1:0]         data_o_8,
`ifdef WIN_COORD_EN
    output logic [$clog2(HEIGHT)-1:0] win_row_o,
    output logic [$clog2(WIDTH)-1:0]  win_col_o,
`endif
    output logic                      valid_o_win,
    output logic                      frame_done_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d, col_eff;
    logic [RW-1:0]     row_q, row_d, row_eff;
    logic              accept, col_last, row_last;
    logic              valid_q, valid_d, done_q, done_d;
    logic [DATA_W-1:0] lb1_q [WIDTH];
    logic [DATA_W-1:0] lb2_q [WIDTH];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];

    assign rdy_o_win = rdy_i_win;

    always_comb begin
        accept   = en_i_win & rdy_i_win;
        // An accepted sof pixel is (0,0) regardless of where the counters are.
        col_eff  = sof_i_win ? '0 : col_q;
        row_eff  = sof_i_win ? '0 : row_q;
        col_last = (col_eff == CW'(WIDTH - 1));
        row_last = (row_eff == RW'(HEIGHT - 1));
        lb1_rd   = lb1_q[col_eff];
        lb2_rd   = lb2_q[col_eff];

        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (accept) begin
            col_d = col_last ? '0 : col_eff + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_eff + RW'(1);
            end else begin
                row_d = row_eff;
            end

            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[2] = lb2_rd;
            win_d[5] = lb1_rd;
            win_d[8] = data_i;

            valid_d = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
            done_d  = row_last && col_last;

            if (sof_i_win) begin
                state_d = S_FILL;
            end else begin
                case (state_q)
                    S_IDLE:  state_d = S_FILL;
                    S_FILL:  if (col_last && row_eff == RW'(1)) state_d = S_RUN;
                    S_RUN:   if (col_last && row_last) state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i_win) begin
        if (rst_i_win) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    // Line buffers carry no reset; stale rows are overwritten before any window uses them.
    always_ff @(posedge clk_i_win) begin
        if (accept && !rst_i_win) begin
            lb2_q[col_eff] <= lb1_rd;
            lb1_q[col_eff] <= data_i;
        end
    end

`ifdef WIN_COORD_EN
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    always_ff @(posedge clk_i_win) begin
        if (rst_i_win) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (valid_d) begin
            win_row_q <= row_eff - RW'(2);
            win_col_q <= col_eff - CW'(2);
        end
    end

    assign win_row_o = win_row_q;
    assign win_col_o = win_col_q;
`endif

    assign valid_o_win  = valid_q;
    assign frame_done_o = done_q;
    assign data_o_0     = win_q[0];
    assign data_o_1     = win_q[1];
    assign data_o_2     = win_q[2];
    assign data_o_3     = win_q[3];
    assign data_o_4     = win_q[4];
    assign data_o_5     = win_q[5];
    assign data_o_6     = win_q[6];
    assign data_o_7     = win_q[7];
    assign data_o_8     = win_q[8];

endmodule
